// File: rtl/gonso_sequencer.sv
// Fetches a range of pixel words from RAM port 1 and serialises them MSB-first as
// pulse-width-encoded bits on dout, followed by a latch gap, repeated w_count times.
`timescale 1ns/1ps
module gonso_sequencer #(
  parameter int TBIT         = 25,
  parameter int T0H          = 8,
  parameter int T1H          = 16,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       controller_en,
  input  logic       polarity,
  input  logic [5:0] w_first,
  input  logic [5:0] w_last,
  input  logic [3:0] w_count,
  input  logic       start,
  output logic       progress,
  output logic       cs1_n,
  output logic [5:0] addr1,
  input  logic [7:0] rdata1,
  output logic       dout
);

  localparam int CMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C     = CW'(T0H);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_BIT, S_LATCH} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic [5:0]    idx_reg, idx_next;
  logic [5:0]    first_reg, first_next;
  logic [5:0]    last_reg, last_next;
  logic [3:0]    iter_reg, iter_next;
  logic          dout_reg;
  logic          raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      idx_reg   <= '0;
      first_reg <= '0;
      last_reg  <= '0;
      iter_reg  <= '0;
      dout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      first_reg <= first_next;
      last_reg  <= last_next;
      iter_reg  <= iter_next;
      // Masking with controller_en makes an abort reach the idle level on the next cycle.
      dout_reg  <= (raw & controller_en) ^ polarity;
    end
  end

  assign raw = (state_reg == S_BIT) && (cyc_reg < (shift_reg[7] ? T1H_C : T0H_C));

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    first_next = first_reg;
    last_next  = last_reg;
    iter_next  = iter_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && controller_en && (w_count != 4'd0)) begin
          first_next = w_first;
          last_next  = w_last;
          iter_next  = w_count;
          idx_next   = w_first;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        shift_next = rdata1;
        bit_next   = 3'd7;
        cyc_next   = '0;
        state_next = S_BIT;
      end
      S_BIT: begin
        if (cyc_reg == TBIT_LAST) begin
          cyc_next   = '0;
          shift_next = {shift_reg[6:0], 1'b0};
          bit_next   = bit_reg - 3'd1;
          if (bit_reg == 3'd0) begin
            if (idx_reg == last_reg) begin
              state_next = S_LATCH;
            end else begin
              idx_next   = idx_reg + 6'd1;
              state_next = S_FETCH;
            end
          end
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end
      S_LATCH: begin
        if (cyc_reg == RST_LAST) begin
          cyc_next  = '0;
          iter_next = iter_reg - 4'd1;
          if (iter_reg == 4'd1) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = first_reg;
            state_next = S_FETCH;
          end
        end else begin
          cyc_next = cyc_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
    if ((state_reg != S_IDLE) && !controller_en) begin
      state_next = S_IDLE;
      cyc_next   = '0;
      bit_next   = '0;
    end
  end

  assign progress = (state_reg != S_IDLE);
  assign cs1_n    = (state_reg != S_FETCH);
  assign addr1    = idx_reg;
  assign dout     = dout_reg;

endmodule

// File: tb/tb_gonso_sequencer.sv
// Self-checking bench: a per-cycle slot queue built from the frame rules predicts
// progress, cs1_n, addr1 and dout; directed frames pin pulse widths and frame lengths.
`timescale 1ns/1ps
module tb_gonso_sequencer;
  localparam int TBIT = 25, T0H = 8, T1H = 16, RC = 1000;
  localparam int WORD = 2 + 8 * TBIT;

  logic       clk = 1'b0;
  logic       rst_n, controller_en, polarity, start;
  logic [5:0] w_first, w_last;
  logic [3:0] w_count;
  logic       progress, cs1_n, dout;
  logic [5:0] addr1;
  logic [7:0] rdata1;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  gonso_sequencer #(.TBIT(TBIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .controller_en(controller_en), .polarity(polarity),
    .w_first(w_first), .w_last(w_last), .w_count(w_count), .start(start),
    .progress(progress), .cs1_n(cs1_n), .addr1(addr1), .rdata1(rdata1), .dout(dout)
  );

  always @(posedge clk) if (!cs1_n) rdata1 <= mem[addr1];

  typedef struct packed { logic raw; logic fetch; logic [5:0] addr; } slot_t;
  slot_t mq[$];
  logic  exp_dout;

  int checks = 0, failures = 0;
  int prog_cnt, falls, run_len;
  int runs[$], fetches[$];
  logic prev_prog;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One queue entry per cycle the frame will occupy.
  function automatic void build(input logic [5:0] f, input logic [5:0] l, input logic [3:0] c);
    logic [5:0] idx;
    logic [7:0] w;
    for (int it = 0; it < int'(c); it++) begin
      idx = f;
      forever begin
        mq.push_back('{raw: 1'b0, fetch: 1'b1, addr: idx});
        mq.push_back('{raw: 1'b0, fetch: 1'b0, addr: 6'd0});
        w = mem[idx];
        for (int b = 7; b >= 0; b--)
          for (int t = 0; t < TBIT; t++)
            mq.push_back('{raw: (t < (w[b] ? T1H : T0H)), fetch: 1'b0, addr: 6'd0});
        if (idx == l) break;
        idx = idx + 6'd1;
      end
      for (int t = 0; t < RC; t++) mq.push_back('{raw: 1'b0, fetch: 1'b0, addr: 6'd0});
    end
  endfunction

  task automatic model_loop();
    logic r;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        exp_dout = 1'b0;
      end else begin
        r = (mq.size() != 0) ? mq[0].raw : 1'b0;
        exp_dout = (r & controller_en) ^ polarity;
        if (mq.size() != 0) begin
          if (!controller_en) mq.delete();
          else void'(mq.pop_front());
        end else if (start && controller_en && w_count != 4'd0) begin
          build(w_first, w_last, w_count);
        end
      end
    end
  endtask

  task automatic compare_loop();
    logic busy, fetch;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy  = (mq.size() != 0);
        fetch = busy && mq[0].fetch;
        chk("progress", int'(progress), int'(busy));
        chk("cs1_n", int'(cs1_n), int'(!fetch));
        if (fetch) chk("addr1", int'(addr1), int'(mq[0].addr));
        chk("dout", int'(dout), int'(exp_dout));
      end
      if (progress) prog_cnt++;
      if (prev_prog && !progress) falls++;
      prev_prog = progress;
      if (!cs1_n) fetches.push_back(int'(addr1));
      if (dout ^ polarity) run_len++;
      else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  endtask

  task automatic clear_meas();
    prog_cnt = 0; falls = 0; run_len = 0;
    runs.delete(); fetches.delete();
  endtask

  task automatic pulse_start(input logic [5:0] f, input logic [5:0] l, input logic [3:0] c);
    @(posedge clk); #2;
    w_first = f; w_last = l; w_count = c; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (progress && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_within_budget", int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [5:0] f, input logic [5:0] l, input logic [3:0] c, input int budget);
    clear_meas();
    pulse_start(f, l, c);
    wait_idle(budget);
  endtask

  initial begin
    int exp1[8] = '{16, 8, 16, 8, 8, 16, 8, 16};
    int exp2[4] = '{62, 63, 0, 1};
    rst_n = 1'b0; controller_en = 1'b0; polarity = 1'b0; start = 1'b0;
    w_first = '0; w_last = '0; w_count = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    prev_prog = 1'b0;
    clear_meas();
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_progress", int'(progress), 0);
    chk("reset_cs1_n", int'(cs1_n), 1);
    chk("reset_addr1", int'(addr1), 0);
    chk("reset_dout", int'(dout), 0);
    @(posedge clk); #2;
    rst_n = 1'b1; controller_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single word A5: pulse widths and frame length.
    mem[0] = 8'hA5;
    frame(6'd0, 6'd0, 4'd1, 3000);
    chk("t1_progress_len", prog_cnt, 1202);
    chk("t1_pulse_count", runs.size(), 8);
    for (int k = 0; k < 8; k++) chk("t1_pulse_width", (k < runs.size()) ? runs[k] : -1, exp1[k]);

    // Wrapping range.
    frame(6'd62, 6'd1, 4'd1, 5000);
    chk("t2_progress_len", prog_cnt, 4 * WORD + RC);
    chk("t2_fetch_count", fetches.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_fetch_addr", (k < fetches.size()) ? fetches[k] : -1, exp2[k]);

    // Three iterations of a two-word range.
    mem[3] = 8'h3C; mem[4] = 8'hC3;
    frame(6'd3, 6'd4, 4'd3, 10000);
    chk("t3_progress_len", prog_cnt, 3 * (2 * WORD + RC));
    chk("t3_falls", falls, 1);
    chk("t3_fetch_count", fetches.size(), 6);

    // Inverted polarity with all-zero word.
    @(posedge clk); #2; polarity = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle_level", int'(dout), 1);
    mem[0] = 8'h00;
    frame(6'd0, 6'd0, 4'd1, 3000);
    chk("t4_low_count", runs.size(), 8);
    for (int k = 0; k < 8; k++) chk("t4_low_width", (k < runs.size()) ? runs[k] : -1, 8);
    chk("t4_after_level", int'(dout), 1);
    @(posedge clk); #2; polarity = 1'b0;

    // Abort during the third bit, then a clean frame.
    mem[0] = 8'hA5;
    clear_meas();
    pulse_start(6'd0, 6'd0, 4'd1);
    repeat (55) @(posedge clk);
    #2; controller_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t5_progress", int'(progress), 0);
    chk("t5_cs1_n", int'(cs1_n), 1);
    chk("t5_dout", int'(dout), 0);
    @(posedge clk); #2; controller_en = 1'b1;
    frame(6'd0, 6'd0, 4'd1, 3000);
    chk("t5_restart_len", prog_cnt, 1202);
    chk("t5_restart_pulses", runs.size(), 8);

    // Start while busy and start with zero count are both ignored.
    clear_meas();
    pulse_start(6'd0, 6'd0, 4'd1);
    repeat (300) @(posedge clk);
    pulse_start(6'd5, 6'd9, 4'd4);
    wait_idle(3000);
    chk("t6_busy_start_len", prog_cnt, 1202);
    chk("t6_busy_fetches", fetches.size(), 1);
    clear_meas();
    pulse_start(6'd0, 6'd3, 4'd0);
    repeat (20) @(negedge clk);
    chk("t6_zero_count_len", prog_cnt, 0);
    chk("t6_zero_count_fetches", fetches.size(), 0);

    // Randomised traffic: starts, aborts, live polarity changes.
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 59) == 0);
      if (start) begin
        w_first = 6'($urandom);
        w_last  = w_first + 6'($urandom_range(0, 3));
        w_count = 4'($urandom_range(0, 2));
      end
      controller_en = ($urandom_range(0, 3999) != 0);
      if ($urandom_range(0, 699) == 0) polarity = ~polarity;
    end
    @(posedge clk); #2;
    start = 1'b0; controller_en = 1'b1; polarity = 1'b0;
    wait_idle(20000);

    // Reset mid-frame, then a clean idle.
    pulse_start(6'd0, 6'd0, 4'd1);
    repeat (100) @(posedge clk);
    #2; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_progress", int'(progress), 0);
    chk("rst_mid_cs1_n", int'(cs1_n), 1);
    chk("rst_mid_dout", int'(dout), 0);
    @(posedge clk); #2; rst_n = 1'b1;
    clear_meas();
    repeat (50) @(negedge clk);
    chk("rst_mid_no_residual", prog_cnt + runs.size() + run_len, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
